// File: rtl/riscv_enc_pkg.sv
// rtl/riscv_enc_pkg.sv - shared types and opcode constants for the RV32I program loader
// Purpose: instruction format and loader state enums, RV32I major opcodes.
// Optional feature macro used by the loader: INST_ENC_CHECKSUM_EN.
package riscv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_WRITE  = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/inst_field_packer.sv
// rtl/inst_field_packer.sv - combinational RV32I field-to-word encoder
// Purpose: assembles R/I/S/B/U/J instruction words from separate fields.
// Ports:
//   fmt            instruction format (0..5 legal, 6/7 illegal)
//   opcode, rd, rs1, rs2, func3, func7, imm   instruction fields
//   word           packed 32-bit instruction (0 when fmt is illegal)
//   legal          high when fmt names a real format
module inst_field_packer
  import riscv_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  // Immediate shifts carry shamt in imm[4:0] and the arithmetic/logical
  // selector in the func7 slot instead of imm[11:5].
  logic is_shift;
  assign is_shift = (opcode == OP_ALUI) && ((func3 == 3'b001) || (func3 == 3'b101));

  always_comb begin
    word  = 32'd0;
    legal = 1'b1;
    case (fmt)
      FMT_R: word = {func7, rs2, rs1, func3, rd, opcode};
      FMT_I: word = is_shift ? {func7, imm[4:0], rs1, func3, rd, opcode}
                             : {imm[11:0], rs1, func3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// rtl/inst_encoder_loader.sv - loads encoded RV32I words into IMEM, holding the core until done
// Purpose: accepts field bundles, encodes them and writes one word per two cycles
// into IMEM starting at BASE_ADDR; releases cpu_hold when the program is loaded.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      restart loading (honoured only when done)
//   in_valid/in_ready/in_last  field bundle handshake, last-instruction marker
//   fmt..imm                   instruction fields
//   imem_we/imem_addr/imem_wdata  IMEM write port
//   cpu_hold, done             core reset hold, load complete
//   err_fmt, err_ovf           sticky illegal-format / IMEM-overflow flags
//   checksum                   sum of written words (only with INST_ENC_CHECKSUM_EN)
module inst_encoder_loader
  import riscv_enc_pkg::*;
#(
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic [31:0]           imm,
  output logic                  imem_we,
  output logic [PC_WIDTH-1:0]   imem_addr,
  output logic [INST_WIDTH-1:0] imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err_fmt,
  output logic                  err_ovf
`ifdef INST_ENC_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);

  localparam int CNT_W = $clog2(IMEM_DEPTH + 1);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_inc;
  logic               last_q;
  logic               hs;
  logic [31:0]        packed_word;
  logic               packed_legal;
  logic               at_depth;

  inst_field_packer u_packer (
    .fmt    (fmt),
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .func3  (func3),
    .func7  (func7),
    .imm    (imm),
    .word   (packed_word),
    .legal  (packed_legal)
  );

  assign hs        = in_valid && in_ready;
  assign count_inc = count + CNT_W'(1);
  assign at_depth  = (count_inc == CNT_W'(IMEM_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACCEPT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCEPT: begin
        if (hs) begin
          if (packed_legal) state_nxt = ST_WRITE;
          else if (in_last) state_nxt = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (last_q || at_depth) state_nxt = ST_DONE;
        else                    state_nxt = ST_ACCEPT;
      end
      ST_DONE: begin
        if (start) state_nxt = ST_ACCEPT;
      end
      default: state_nxt = ST_ACCEPT;
    endcase
  end

  // Decoded from state so that imem_we drops the instant rst_n asserts.
  always_comb begin
    in_ready = 1'b0;
    imem_we  = 1'b0;
    done     = 1'b0;
    cpu_hold = 1'b1;
    case (state)
      ST_ACCEPT: in_ready = 1'b1;
      ST_WRITE:  imem_we  = 1'b1;
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_addr  <= PC_WIDTH'(BASE_ADDR);
      imem_wdata <= '0;
      count      <= '0;
      last_q     <= 1'b0;
      err_fmt    <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      case (state)
        ST_ACCEPT: begin
          if (hs) begin
            if (packed_legal) begin
              imem_wdata <= INST_WIDTH'(packed_word);
              last_q     <= in_last;
            end else begin
              err_fmt <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          imem_addr <= imem_addr + PC_WIDTH'(4);
          count     <= count_inc;
          // A final word that exactly fills IMEM is not an overflow.
          if (!last_q && at_depth) err_ovf <= 1'b1;
        end
        ST_DONE: begin
          if (start) begin
            imem_addr <= PC_WIDTH'(BASE_ADDR);
            count     <= '0;
            err_fmt   <= 1'b0;
            err_ovf   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef INST_ENC_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         checksum <= 32'd0;
    else if (state == ST_WRITE)         checksum <= checksum + 32'(imem_wdata);
    else if (state == ST_DONE && start) checksum <= 32'd0;
  end
`endif

endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb/tb_inst_encoder_loader.sv - self-checking bench for inst_encoder_loader
module tb_inst_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [2:0]  fmt = 3'd0;
  logic [6:0]  opcode = 7'd0;
  logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [2:0]  func3 = 3'd0;
  logic [6:0]  func7 = 7'd0;
  logic [31:0] imm = 32'd0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold, done, err_fmt, err_ovf;
`ifdef INST_ENC_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] exp_sum = 32'd0;

  always #5 clk = ~clk;

  inst_encoder_loader #(
    .INST_WIDTH (32),
    .PC_WIDTH   (32),
    .IMEM_DEPTH (4),
    .BASE_ADDR  (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .fmt        (fmt),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .func3      (func3),
    .func7      (func7),
    .imm        (imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err_fmt    (err_fmt),
    .err_ovf    (err_ovf)
`ifdef INST_ENC_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoding built from bit positions with shifts and masks.
  function automatic logic [31:0] model_enc(input logic [31:0] f, input logic [31:0] op,
      input logic [31:0] d, input logic [31:0] s1, input logic [31:0] s2,
      input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] im);
    logic [31:0] base;
    base = (s1 << 15) | (f3 << 12) | op;
    case (f)
      0: return (f7 << 25) | (s2 << 20) | base | (d << 7);
      1: if (op == 32'h13 && (f3 == 1 || f3 == 5))
           return (f7 << 25) | ((im & 32'h1f) << 20) | base | (d << 7);
         else
           return ((im & 32'hfff) << 20) | base | (d << 7);
      2: return (((im >> 5) & 32'h7f) << 25) | (s2 << 20) | base | ((im & 32'h1f) << 7);
      3: return (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3f) << 25) | (s2 << 20) | base
                | (((im >> 1) & 32'hf) << 8) | (((im >> 11) & 1) << 7);
      4: return (im & 32'hfffff000) | (d << 7) | op;
      5: return (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3ff) << 21) | (((im >> 11) & 1) << 20)
                | (((im >> 12) & 32'hff) << 12) | (d << 7) | op;
      default: return 32'd0;
    endcase
  endfunction

  // Starts and returns just after a falling edge; on return the bench sits in
  // the cycle after the handshake.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] im, input logic last, input logic [31:0] exp_word);
    int t;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; func3 = f3; func7 = f7; imm = im;
    in_last = last; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    if (f < 3'd6) begin
      check("we", {31'd0, imem_we}, 32'd1);
      check("addr", imem_addr, exp_addr);
      check("wdata", imem_wdata, exp_word);
      exp_addr += 4;
      exp_sum += exp_word;
    end else begin
      check("no_we_illegal", {31'd0, imem_we}, 32'd0);
      check("err_fmt_set", {31'd0, err_fmt}, 32'd1);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = 32'd0;
    exp_sum = 32'd0;
    check("restart_addr", imem_addr, 32'd0);
    check("restart_hold", {31'd0, cpu_hold}, 32'd1);
    check("restart_done", {31'd0, done}, 32'd0);
    check("restart_errs", {30'd0, err_fmt, err_ovf}, 32'd0);
    check("restart_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic expect_done(input logic e_fmt, input logic e_ovf);
    @(negedge clk);
    check("done", {31'd0, done}, 32'd1);
    check("hold_released", {31'd0, cpu_hold}, 32'd0);
    check("done_not_ready", {31'd0, in_ready}, 32'd0);
    check("done_errs", {30'd0, err_fmt, err_ovf}, {30'd0, e_fmt, e_ovf});
`ifdef INST_ENC_CHECKSUM_EN
    check("checksum", checksum, exp_sum);
`endif
  endtask

  initial begin
    logic [2:0]  rf;
    logic [6:0]  rop;
    logic [4:0]  rrd, rrs1, rrs2;
    logic [2:0]  rf3;
    logic [6:0]  rf7;
    logic [31:0] rimm;
    int          nw;

    // Reset state.
    #12;
    @(negedge clk);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_flags", {27'd0, cpu_hold, done, err_fmt, err_ovf, in_ready}, 32'b1_0001);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;              // ignored outside DONE
    @(negedge clk);
    start = 1'b0;
    check("start_ignored", {30'd0, in_ready, done}, 32'b10);

    // add x3,x1,x2
    send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3);
    expect_done(1'b0, 1'b0);
    @(negedge clk);
    check("we_one_cycle", {31'd0, imem_we}, 32'd0);
    pulse_start();

    // addi x5,x0,-1 ; sw x5,8(x2)
    send(3'd1, 7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF00293);
    send(3'd2, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8, 1'b1, 32'h00512423);
    expect_done(1'b0, 1'b0);
    pulse_start();

    // beq x1,x2,-8 ; jal x1,2048
    send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFF8, 1'b0, 32'hFE208CE3);
    send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 32'h001000EF);
    expect_done(1'b0, 1'b0);
    pulse_start();

    // lui x7,0x12345 ; srai x4,x4,3
    send(3'd4, 7'b0110111, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0, 32'h123453B7);
    send(3'd1, 7'b0010011, 5'd4, 5'd4, 5'd0, 3'd5, 7'b0100000, 32'd3, 1'b1, 32'h40325213);
    expect_done(1'b0, 1'b0);
    pulse_start();

    // Illegal fmt then a legal bundle at address 0.
    send(3'd6, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
    check("illegal_addr_held", imem_addr, 32'd0);
    send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3);
    expect_done(1'b1, 1'b0);
    pulse_start();

    // Overflow: four writes fill IMEM_DEPTH=4, fifth bundle is refused.
    for (int i = 0; i < 4; i++)
      send(3'd1, 7'b0010011, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), 1'b0,
           32'h00000013 | (32'(i) << 20) | (32'(i + 1) << 7));
    expect_done(1'b0, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ovf_refused", {30'd0, in_ready, imem_we}, 32'd0);
    end
    in_valid = 1'b0;
    pulse_start();

    // Reset during WRITE drops imem_we at once.
    fmt = 3'd0; opcode = 7'b0110011; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2;
    func3 = 3'd0; func7 = 7'd0; in_last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_we", {31'd0, imem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_we_async", {31'd0, imem_we}, 32'd0);
    check("rst_addr_async", imem_addr, 32'd0);
    check("rst_hold_async", {31'd0, cpu_hold}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_addr = 32'd0;
    exp_sum = 32'd0;

    // Randomized loads against the reference encoder.
    for (int l = 0; l < 12; l++) begin
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(0, 4) == 0) begin
          send(3'($urandom_range(6, 7)), 7'($urandom), 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
        end
        rf   = 3'($urandom_range(0, 5));
        rop  = ($urandom_range(0, 1) == 1) ? 7'b0010011 : 7'($urandom);
        rrd  = 5'($urandom);
        rrs1 = 5'($urandom);
        rrs2 = 5'($urandom);
        rf3  = 3'($urandom);
        rf7  = 7'($urandom);
        rimm = $urandom;
        send(rf, rop, rrd, rrs1, rrs2, rf3, rf7, rimm, (w == nw - 1),
             model_enc(32'(rf), 32'(rop), 32'(rrd), 32'(rrs1), 32'(rrs2), 32'(rf3), 32'(rf7), rimm));
      end
      @(negedge clk);
      check("rand_done", {30'd0, done, cpu_hold}, 32'b10);
      check("rand_ovf", {31'd0, err_ovf}, 32'd0);
`ifdef INST_ENC_CHECKSUM_EN
      check("rand_checksum", checksum, exp_sum);
`endif
      pulse_start();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
